// File: rtl/traffic_phase_timer.sv
// Phase timer for the one-way traffic light: divides clk into 1 s ticks, counts each
// phase duration and strobes `advance` in the first cycle of every new phase.
module traffic_phase_timer #(
    parameter int TICKS_PER_SEC = 50000000,
    parameter int RED_SEC       = 30,
    parameter int RED_YEL_SEC   = 3,
    parameter int GREEN_SEC     = 30,
    parameter int YEL_SEC       = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       hold,
    output logic [2:0] phase,
    output logic       advance,
    output logic       sec_tick,
    output logic [5:0] secs_left
);

    localparam int PW = $clog2(TICKS_PER_SEC);
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_SEC - 1);

    if (TICKS_PER_SEC < 2) begin : g_bad_ticks
        $error("traffic_phase_timer: TICKS_PER_SEC must be >= 2");
    end
    if (RED_SEC < 1 || RED_SEC > 63) begin : g_bad_red
        $error("traffic_phase_timer: RED_SEC must be 1..63");
    end
    if (RED_YEL_SEC < 1 || RED_YEL_SEC > 63) begin : g_bad_red_yel
        $error("traffic_phase_timer: RED_YEL_SEC must be 1..63");
    end
    if (GREEN_SEC < 1 || GREEN_SEC > 63) begin : g_bad_green
        $error("traffic_phase_timer: GREEN_SEC must be 1..63");
    end
    if (YEL_SEC < 1 || YEL_SEC > 63) begin : g_bad_yel
        $error("traffic_phase_timer: YEL_SEC must be 1..63");
    end

    typedef enum logic [2:0] {
        PH_DISABLE    = 3'd0,
        PH_STOP       = 3'd1,
        PH_READY_GO   = 3'd2,
        PH_GO         = 3'd3,
        PH_READY_STOP = 3'd4
    } phase_e;

    phase_e          phase_q;
    phase_e          phase_d;
    logic [PW-1:0]   presc_q;
    logic [5:0]      secs_q;
    logic            adv_q;
    logic            tick_q;
    logic            running;
    logic            wrap;

    function automatic phase_e next_phase(input phase_e p);
        case (p)
            PH_STOP:     next_phase = PH_READY_GO;
            PH_READY_GO: next_phase = PH_GO;
            PH_GO:       next_phase = PH_READY_STOP;
            default:     next_phase = PH_STOP;
        endcase
    endfunction

    function automatic logic [5:0] phase_secs(input phase_e p);
        case (p)
            PH_STOP:       phase_secs = 6'(RED_SEC);
            PH_READY_GO:   phase_secs = 6'(RED_YEL_SEC);
            PH_GO:         phase_secs = 6'(GREEN_SEC);
            PH_READY_STOP: phase_secs = 6'(YEL_SEC);
            default:       phase_secs = 6'd0;
        endcase
    endfunction

    // Only legal running phases count; any other non-DISABLE code falls back to DISABLE.
    assign running = (phase_q == PH_STOP) || (phase_q == PH_READY_GO) ||
                     (phase_q == PH_GO)   || (phase_q == PH_READY_STOP);
    assign wrap    = running && !hold && (presc_q == PRESC_LAST);
    assign phase_d = next_phase(phase_q);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            phase_q <= PH_DISABLE;
            presc_q <= '0;
            secs_q  <= 6'd0;
            adv_q   <= 1'b0;
            tick_q  <= 1'b0;
        end else begin
            adv_q  <= 1'b0;
            tick_q <= 1'b0;
            if (phase_q != PH_DISABLE && (!enable || !running)) begin
                phase_q <= PH_DISABLE;
                presc_q <= '0;
                secs_q  <= 6'd0;
                adv_q   <= 1'b1;
            end else if (phase_q == PH_DISABLE && enable) begin
                phase_q <= PH_STOP;
                presc_q <= '0;
                secs_q  <= 6'(RED_SEC);
                adv_q   <= 1'b1;
            end else if (running && !hold) begin
                tick_q <= wrap;
                if (wrap) begin
                    presc_q <= '0;
                    if (secs_q == 6'd1) begin
                        phase_q <= phase_d;
                        secs_q  <= phase_secs(phase_d);
                        adv_q   <= 1'b1;
                    end else begin
                        secs_q <= secs_q - 6'd1;
                    end
                end else begin
                    presc_q <= presc_q + PW'(1);
                end
            end
        end
    end

    assign phase     = phase_q;
    assign advance   = adv_q;
    assign sec_tick  = tick_q;
    assign secs_left = secs_q;

endmodule

// File: tb/tb_traffic_phase_timer.sv
// Bench for traffic_phase_timer: a default-duration instance and a short-duration
// instance, both checked cycle by cycle against an elapsed-cycle reference model.
module tb_traffic_phase_timer;

    localparam int T1 = 4, R1 = 30, RY1 = 3, G1 = 30, Y1 = 3;
    localparam int T2 = 2, R2 = 1,  RY2 = 3, G2 = 30, Y2 = 1;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable, hold, enable2, hold2;
    logic [2:0] phase1, phase2;
    logic       advance1, advance2, sec_tick1, sec_tick2;
    logic [5:0] secs_left1, secs_left2;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    traffic_phase_timer #(.TICKS_PER_SEC(T1)) u_dut1 (
        .clk(clk), .rst(rst), .enable(enable), .hold(hold),
        .phase(phase1), .advance(advance1), .sec_tick(sec_tick1), .secs_left(secs_left1)
    );

    traffic_phase_timer #(.TICKS_PER_SEC(T2), .RED_SEC(R2), .RED_YEL_SEC(RY2),
                          .GREEN_SEC(G2), .YEL_SEC(Y2)) u_dut2 (
        .clk(clk), .rst(rst), .enable(enable2), .hold(hold2),
        .phase(phase2), .advance(advance2), .sec_tick(sec_tick2), .secs_left(secs_left2)
    );

    // Reference: phase plus number of counted cycles elapsed since its advance.
    typedef struct {
        int ph;
        int e;
        bit adv;
        bit tick;
    } mst_t;

    mst_t m1, m2;

    function automatic int dur_of(input int ph, input int a, input int b, input int c, input int d);
        case (ph)
            1: return a;
            2: return b;
            3: return c;
            4: return d;
            default: return 0;
        endcase
    endfunction

    function automatic mst_t mstep(input mst_t s, input bit en, input bit hd, input int T,
                                   input int a, input int b, input int c, input int d);
        mst_t n;
        n = s;
        n.adv = 1'b0;
        n.tick = 1'b0;
        if (s.ph != 0 && !en) begin
            n.ph = 0; n.e = 0; n.adv = 1'b1;
        end else if (s.ph == 0 && en) begin
            n.ph = 1; n.e = 0; n.adv = 1'b1;
        end else if (s.ph != 0 && !hd) begin
            n.e = s.e + 1;
            n.tick = (n.e % T) == 0;
            if (n.e == dur_of(s.ph, a, b, c, d) * T) begin
                n.ph = (s.ph % 4) + 1; n.e = 0; n.adv = 1'b1;
            end
        end
        return n;
    endfunction

    function automatic logic [10:0] mexp(input mst_t s, input int T,
                                         input int a, input int b, input int c, input int d);
        int sl;
        int ph;
        ph = s.ph;
        sl = (s.ph == 0) ? 0 : dur_of(s.ph, a, b, c, d) - s.e / T;
        return {ph[2:0], s.adv, s.tick, sl[5:0]};
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m1 <= '{ph: 0, e: 0, adv: 1'b0, tick: 1'b0};
            m2 <= '{ph: 0, e: 0, adv: 1'b0, tick: 1'b0};
        end else begin
            m1 <= mstep(m1, enable, hold, T1, R1, RY1, G1, Y1);
            m2 <= mstep(m2, enable2, hold2, T2, R2, RY2, G2, Y2);
        end
    end

    logic [10:0] obs1, obs2, exp1, exp2;
    assign obs1 = {phase1, advance1, sec_tick1, secs_left1};
    assign obs2 = {phase2, advance2, sec_tick2, secs_left2};
    always_comb exp1 = mexp(m1, T1, R1, RY1, G1, Y1);
    always_comb exp2 = mexp(m2, T2, R2, RY2, G2, Y2);

    task automatic test_reset();
        rst = 1'b0; enable = 1'b0; hold = 1'b0; enable2 = 1'b0; hold2 = 1'b0;
        repeat (2) @(negedge clk);
        n_tests++;
        if (obs1 !== 11'd0) begin n_fail++; $display("FAIL reset_dut1: got %h expected %h", obs1, 11'd0); end
        n_tests++;
        if (obs2 !== 11'd0) begin n_fail++; $display("FAIL reset_dut2: got %h expected %h", obs2, 11'd0); end
        enable = 1'b1;
        @(negedge clk);
        n_tests++;
        if (obs1 !== 11'd0) begin n_fail++; $display("FAIL reset_dominates: got %h expected %h", obs1, 11'd0); end
    endtask

    task automatic test_startup();
        enable2 = 1'b1;
        #2 rst = 1'b1;
        @(negedge clk);
        n_tests++;
        if (obs1 !== {3'd1, 1'b1, 1'b0, 6'd30}) begin
            n_fail++; $display("FAIL startup_dut1: got %h expected %h", obs1, {3'd1, 1'b1, 1'b0, 6'd30});
        end
        n_tests++;
        if (obs2 !== {3'd1, 1'b1, 1'b0, 6'd1}) begin
            n_fail++; $display("FAIL startup_dut2: got %h expected %h", obs2, {3'd1, 1'b1, 1'b0, 6'd1});
        end
        @(negedge clk);
        n_tests++;
        if (advance1 !== 1'b0) begin n_fail++; $display("FAIL startup_adv_low: got %b expected 0", advance1); end
    endtask

    task automatic test_full_cycle();
        int exp_k[4];
        int exp_ph[4];
        int na;
        exp_k[0] = R1 * T1;              exp_ph[0] = 2;
        exp_k[1] = exp_k[0] + RY1 * T1;  exp_ph[1] = 3;
        exp_k[2] = exp_k[1] + G1 * T1;   exp_ph[2] = 4;
        exp_k[3] = exp_k[2] + Y1 * T1;   exp_ph[3] = 1;
        na = 0;
        for (int k = 2; k <= exp_k[3]; k++) begin
            @(negedge clk);
            n_tests++;
            if (obs1 !== exp1) begin n_fail++; $display("FAIL cycle_model k=%0d: got %h expected %h", k, obs1, exp1); end
            if (advance1) begin
                if (na < 4) begin
                    n_tests++;
                    if (k != exp_k[na] || int'(phase1) != exp_ph[na]) begin
                        n_fail++;
                        $display("FAIL cycle_advance: got k=%0d phase=%0d expected k=%0d phase=%0d",
                                 k, phase1, exp_k[na], exp_ph[na]);
                    end
                end
                na++;
            end
        end
        n_tests++;
        if (na != 4) begin n_fail++; $display("FAIL cycle_advance_count: got %0d expected 4", na); end
    endtask

    task automatic test_hold();
        bit found;
        int cnt;
        found = 1'b0;
        for (int i = 0; i < 400 && !found; i++) begin
            @(negedge clk);
            if (phase1 == 3'd3 && secs_left1 == 6'd10) found = 1'b1;
        end
        n_tests++;
        if (!found) begin
            n_fail++; $display("FAIL hold_wait: got timeout expected GO with 10 s left");
        end else begin
            hold = 1'b1;
            cnt = 0;
            repeat (7) begin
                @(negedge clk);
                cnt++;
                n_tests++;
                if ({secs_left1, sec_tick1, advance1} !== {6'd10, 1'b0, 1'b0} || obs1 !== exp1) begin
                    n_fail++; $display("FAIL hold_freeze: got %h expected %h", obs1, exp1);
                end
            end
            hold = 1'b0;
            while (phase1 != 3'd4 && cnt < 100) begin
                @(negedge clk);
                cnt++;
            end
            n_tests++;
            if (cnt != 47) begin n_fail++; $display("FAIL hold_extend: got %0d cycles expected 47", cnt); end
        end
    endtask

    task automatic test_disable_race();
        bit found;
        bit saw_rg;
        found = 1'b0;
        saw_rg = 1'b0;
        for (int i = 0; i < 400 && !found; i++) begin
            @(negedge clk);
            if (phase1 == 3'd1 && secs_left1 == 6'd1) found = 1'b1;
        end
        n_tests++;
        if (!found) begin
            n_fail++; $display("FAIL race_wait: got timeout expected STOP with 1 s left");
        end else begin
            repeat (3) @(negedge clk);
            enable = 1'b0;
            @(negedge clk);
            n_tests++;
            if (obs1 !== {3'd0, 1'b1, 1'b0, 6'd0}) begin
                n_fail++; $display("FAIL race_disable: got %h expected %h", obs1, {3'd0, 1'b1, 1'b0, 6'd0});
            end
            repeat (5) begin
                @(negedge clk);
                if (phase1 == 3'd2) saw_rg = 1'b1;
            end
            n_tests++;
            if (saw_rg || obs1 !== 11'd0) begin
                n_fail++; $display("FAIL race_stays_disabled: got %h rg=%0d expected 000 rg=0", obs1, saw_rg);
            end
            enable = 1'b1;
            @(negedge clk);
            n_tests++;
            if (obs1 !== {3'd1, 1'b1, 1'b0, 6'd30}) begin
                n_fail++; $display("FAIL race_reenable: got %h expected %h", obs1, {3'd1, 1'b1, 1'b0, 6'd30});
            end
        end
    endtask

    task automatic test_async_reset();
        bit found;
        found = 1'b0;
        for (int i = 0; i < 400 && !found; i++) begin
            @(negedge clk);
            if (phase1 == 3'd3) found = 1'b1;
        end
        n_tests++;
        if (!found) begin
            n_fail++; $display("FAIL areset_wait: got timeout expected GO");
        end else begin
            @(negedge clk);
            #2 rst = 1'b0;
            #1;
            n_tests++;
            if (obs1 !== 11'd0 || obs2 !== 11'd0) begin
                n_fail++; $display("FAIL areset_immediate: got %h/%h expected 000/000", obs1, obs2);
            end
            @(negedge clk);
            #2 rst = 1'b1;
            @(negedge clk);
            n_tests++;
            if (obs1 !== {3'd1, 1'b1, 1'b0, 6'd30} || obs2 !== {3'd1, 1'b1, 1'b0, 6'd1}) begin
                n_fail++; $display("FAIL areset_restart: got %h/%h expected %h/%h", obs1, obs2,
                                   {3'd1, 1'b1, 1'b0, 6'd30}, {3'd1, 1'b1, 1'b0, 6'd1});
            end
        end
    endtask

    task automatic test_short_params();
        int exp_k[4];
        int exp_ph[4];
        int na;
        exp_k[0] = R2 * T2;              exp_ph[0] = 2;
        exp_k[1] = exp_k[0] + RY2 * T2;  exp_ph[1] = 3;
        exp_k[2] = exp_k[1] + G2 * T2;   exp_ph[2] = 4;
        exp_k[3] = exp_k[2] + Y2 * T2;   exp_ph[3] = 1;
        na = 0;
        for (int k = 1; k <= exp_k[3]; k++) begin
            @(negedge clk);
            n_tests++;
            if (obs2 !== exp2 || (phase2 != 3'd0 && secs_left2 == 6'd0)) begin
                n_fail++; $display("FAIL short_model k=%0d: got %h expected %h", k, obs2, exp2);
            end
            if (advance2) begin
                if (na < 4) begin
                    n_tests++;
                    if (k != exp_k[na] || int'(phase2) != exp_ph[na]) begin
                        n_fail++;
                        $display("FAIL short_advance: got k=%0d phase=%0d expected k=%0d phase=%0d",
                                 k, phase2, exp_k[na], exp_ph[na]);
                    end
                end
                na++;
            end
        end
        n_tests++;
        if (na != 4) begin n_fail++; $display("FAIL short_advance_count: got %0d expected 4", na); end
    endtask

    task automatic test_enable_with_hold();
        enable = 1'b0;
        repeat (2) @(negedge clk);
        n_tests++;
        if (obs1 !== 11'd0) begin n_fail++; $display("FAIL eh_disabled: got %h expected 000", obs1); end
        enable = 1'b1;
        hold = 1'b1;
        @(negedge clk);
        n_tests++;
        if (obs1 !== {3'd1, 1'b1, 1'b0, 6'd30}) begin
            n_fail++; $display("FAIL eh_enter_stop: got %h expected %h", obs1, {3'd1, 1'b1, 1'b0, 6'd30});
        end
        repeat (3) begin
            @(negedge clk);
            n_tests++;
            if (obs1 !== {3'd1, 1'b0, 1'b0, 6'd30}) begin
                n_fail++; $display("FAIL eh_frozen: got %h expected %h", obs1, {3'd1, 1'b0, 1'b0, 6'd30});
            end
        end
        hold = 1'b0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(0, 199) < 2) enable = ~enable;
            if ($urandom_range(0, 199) < 3) enable2 = ~enable2;
            hold  = ($urandom_range(0, 99) < 15);
            hold2 = ($urandom_range(0, 99) < 20);
            @(negedge clk);
            n_tests++;
            if (obs1 !== exp1) begin n_fail++; $display("FAIL random_dut1 i=%0d: got %h expected %h", i, obs1, exp1); end
            n_tests++;
            if (obs2 !== exp2) begin n_fail++; $display("FAIL random_dut2 i=%0d: got %h expected %h", i, obs2, exp2); end
        end
        hold = 1'b0;
        hold2 = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected bench completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_startup();
        test_full_cycle();
        test_hold();
        test_disable_race();
        test_async_reset();
        test_short_params();
        test_enable_with_hold();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/traffic_phase_timer.md
Name: traffic_phase_timer

Overview:
Upstream timing stage for the one-way traffic light controller. It divides the system clock into 1 s ticks and counts each phase duration (RED 30 s, RED+YELLOW 3 s, GREEN 30 s, YELLOW 3 s). It issues a one-cycle advance strobe and the current phase code, so the light-decoding FSM downstream steps exactly once per elapsed phase. It also exposes the seconds remaining in the current phase for a countdown display.

Parameters:
TICKS_PER_SEC, 50000000, clk cycles per second; must be >= 2.
RED_SEC, 30, STOP phase duration in seconds; range 1..63.
RED_YEL_SEC, 3, READY_TO_GO phase duration in seconds; range 1..63.
GREEN_SEC, 30, GO phase duration in seconds; range 1..63.
YEL_SEC, 3, READY_TO_STOP phase duration in seconds; range 1..63.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous, active-low reset (0 = reset).
enable  input  1  run request; 0 forces the DISABLE phase.
hold  input  1  freezes the prescaler and countdown while 1 (maintenance/override).
phase  output  3  current phase: 000 DISABLE, 001 STOP, 010 READY_TO_GO, 011 GO, 100 READY_TO_STOP.
advance  output  1  one-cycle strobe, high in the first cycle of every new phase.
sec_tick  output  1  one-cycle strobe on each elapsed second (prescaler wrap).
secs_left  output  6  seconds remaining in the current phase; 0 in DISABLE.

Behaviour:
- Reset (rst=0, asynchronous): phase=000, advance=0, sec_tick=0, secs_left=0, prescaler=0. All outputs are registered and take these values immediately, without waiting for a clock edge.
- Prescaler: counter of width clog2(TICKS_PER_SEC). It counts 0..TICKS_PER_SEC-1 only while phase!=DISABLE and hold=0. sec_tick is registered high for one cycle on the edge where the count wraps to 0. The prescaler clears to 0 on every phase change.
- FSM transitions, evaluated on the rising edge in priority order:
  1. enable=0 and phase!=DISABLE -> DISABLE, secs_left=0, advance=1.
  2. phase=DISABLE and enable=1 -> STOP, secs_left=RED_SEC, advance=1.
  3. Wrap edge with hold=0 and secs_left==1 -> next phase, secs_left loaded with that phase's duration, advance=1. Phase order: STOP->READY_TO_GO->GO->READY_TO_STOP->STOP.
  4. Wrap edge with hold=0 and secs_left>1 -> secs_left decrements by 1.
  5. Otherwise all state holds and advance=0.
- Phase length: each non-DISABLE phase lasts exactly duration*TICKS_PER_SEC cycles, counted from its advance cycle (inclusive) to the next advance. A full cycle is (RED_SEC+RED_YEL_SEC+GREEN_SEC+YEL_SEC)*TICKS_PER_SEC cycles.
- hold=1: the prescaler, secs_left and phase are frozen, and no sec_tick or advance is produced. The phase is extended by exactly the number of held cycles. hold has no effect on rule 1 or rule 2.
- Simultaneous events: enable falling on the same edge as a final-second wrap -> DISABLE wins; no intermediate phase is emitted. enable=1 together with hold=1 while in DISABLE -> enter STOP, then freeze.
- Illegal phase code (101..111): return to DISABLE on the next edge with advance=1.
- Reset mid-phase: the sequence restarts from DISABLE. The first advance after reset always presents phase=001.
- Elaboration error if any *_SEC parameter is 0 or >63, or if TICKS_PER_SEC<2.

Test Plan:
1. TICKS_PER_SEC=4, defaults. Release reset with enable=1 -> on the first edge, phase=001, advance=1, secs_left=30. advance=0 on the following cycle.
2. Continue from 1 -> phase=010 exactly 120 cycles after the first advance, then 011 at +12, 100 at +120, 001 at +12. Full loop is 264 cycles. Exactly 4 advance pulses per loop; secs_left steps 30..1 every 4 cycles.
3. In GO with secs_left=10, assert hold for 7 cycles -> secs_left stays 10, no sec_tick; the transition to 100 arrives 7 cycles later than in run 2.
4. Drop enable in the same cycle as the final STOP second wraps -> phase=000, secs_left=0, one advance pulse; phase 010 is never presented. Reassert enable -> phase=001, secs_left=30.
5. Pull rst low asynchronously mid-GREEN, between clock edges -> all outputs 0 before the next clk edge. Release with enable=1 -> the sequence restarts at phase 001.
6. Parameter override RED_SEC=1, YEL_SEC=1, TICKS_PER_SEC=2 -> STOP lasts 2 cycles and READY_TO_STOP lasts 2 cycles; secs_left never shows 0 outside DISABLE.
